// File: rtl/usr_irq_pkg.sv
// Shared constants for the user-interrupt slave and the master stage that feeds it.
package usr_irq_pkg;

    localparam logic [3:0] ADDR_REQ     = 4'd0;
    localparam logic [3:0] ADDR_STATUS  = 4'd1;
    localparam logic [3:0] ADDR_MASK    = 4'd2;
    localparam logic [3:0] ADDR_CTRL    = 4'd3;
    localparam logic [3:0] ADDR_COUNT   = 4'd4;
    localparam logic [3:0] ADDR_HOLDOFF = 4'd5;

    // Word values the master stage writes on request rising/falling edges.
    localparam logic [31:0] IRQ_SET = 32'h1;
    localparam logic [31:0] IRQ_CLR = 32'h0;

endpackage

// File: rtl/usr_irq_holdoff.sv
// Loadable down-counter; zero is high whenever the holdoff window has expired.
module usr_irq_holdoff #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] reload_value,
    output logic         zero
);

    logic [W-1:0] cnt;

    // A load always wins, so a second acknowledge restarts the window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= reload_value;
        end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/usr_irq_slave.sv
// Avalon-MM slave terminating user-interrupt writes and driving a level IRQ to the CPU.
module usr_irq_slave
    import usr_irq_pkg::*;
#(
    parameter int CNT_W     = 16,
    parameter int HOLDOFF_W = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        avs_chipselect,
    input  logic [3:0]  avs_address,
    input  logic        avs_read,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    output logic        avs_waitrequest,
    output logic [31:0] avs_readdata,
    output logic        irq
);

    logic                 level;
    logic                 pending;
    logic                 mask;
    logic                 mode;
    logic [CNT_W-1:0]     count;
    logic [HOLDOFF_W-1:0] holdoff_reload;
    logic                 rd_ack;
    logic                 holdoff_zero;

    logic        wr_en;
    logic        rd_start;
    logic        rise;
    logic        ack;
    logic [31:0] rd_mux;

    assign wr_en    = avs_chipselect & avs_write;
    assign rd_start = avs_chipselect & avs_read & ~avs_write & ~rd_ack;
    assign rise     = wr_en & (avs_address == ADDR_REQ) & avs_writedata[0] & ~level;
    assign ack      = wr_en & (avs_address == ADDR_STATUS) & avs_writedata[0];

    // Gated by rst_n so an in-flight read is dropped the moment reset asserts.
    assign avs_waitrequest = rst_n & rd_start;

    always_comb begin
        rd_mux = 32'h0;
        case (avs_address)
            ADDR_REQ:     rd_mux = {31'b0, level};
            ADDR_STATUS:  rd_mux = {31'b0, pending};
            ADDR_MASK:    rd_mux = {31'b0, mask};
            ADDR_CTRL:    rd_mux = {31'b0, mode};
            ADDR_COUNT:   rd_mux = 32'(count);
            ADDR_HOLDOFF: rd_mux = 32'(holdoff_reload);
            default:      rd_mux = 32'h0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level          <= 1'b0;
            pending        <= 1'b0;
            mask           <= 1'b0;
            mode           <= 1'b0;
            count          <= '0;
            holdoff_reload <= '0;
        end else if (wr_en) begin
            case (avs_address)
                ADDR_REQ:     level <= avs_writedata[0];
                ADDR_MASK:    mask <= avs_writedata[0];
                ADDR_CTRL:    mode <= avs_writedata[0];
                ADDR_COUNT:   count <= '0;
                ADDR_HOLDOFF: holdoff_reload <= avs_writedata[HOLDOFF_W-1:0];
                default:      ;
            endcase
            if (rise) begin
                pending <= 1'b1;
                count   <= count + CNT_W'(1);
            end
            if (ack) begin
                pending <= 1'b0;
            end
        end
    end

    // One wait state: the data is captured on the edge that sets rd_ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ack       <= 1'b0;
            avs_readdata <= 32'h0;
        end else begin
            rd_ack <= rd_start;
            if (rd_start) begin
                avs_readdata <= rd_mux;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq <= 1'b0;
        end else begin
            irq <= mask & holdoff_zero & (mode ? level : pending);
        end
    end

    usr_irq_holdoff #(
        .W(HOLDOFF_W)
    ) u_holdoff (
        .clk          (clk),
        .rst_n        (rst_n),
        .load         (ack),
        .reload_value (holdoff_reload),
        .zero         (holdoff_zero)
    );

endmodule

// File: tb/tb_usr_irq_slave.sv
// Directed bench for usr_irq_slave built with a 4-bit event counter so wrap is reachable.
module tb_usr_irq_slave;
    import usr_irq_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        avs_chipselect;
    logic [3:0]  avs_address;
    logic        avs_read;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic        avs_waitrequest;
    logic [31:0] avs_readdata;
    logic        irq;

    int checks = 0;
    int errors = 0;

    usr_irq_slave #(
        .CNT_W     (4),
        .HOLDOFF_W (16)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .avs_chipselect  (avs_chipselect),
        .avs_address     (avs_address),
        .avs_read        (avs_read),
        .avs_write       (avs_write),
        .avs_writedata   (avs_writedata),
        .avs_waitrequest (avs_waitrequest),
        .avs_readdata    (avs_readdata),
        .irq             (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Tasks are entered 1ns after a rising edge and return 1ns after the sampling edge.
    task automatic applyStimulus(input logic [3:0] addr, input logic [31:0] data);
        avs_chipselect = 1'b1;
        avs_write      = 1'b1;
        avs_read       = 1'b0;
        avs_address    = addr;
        avs_writedata  = data;
        #1;
        checkOutput($sformatf("wr_wait_a%0d", addr), 32'(avs_waitrequest), 32'h0);
        @(posedge clk);
        #1;
        avs_chipselect = 1'b0;
        avs_write      = 1'b0;
    endtask

    task automatic readReg(input logic [3:0] addr, output logic [31:0] data);
        avs_chipselect = 1'b1;
        avs_read       = 1'b1;
        avs_write      = 1'b0;
        avs_address    = addr;
        #1;
        checkOutput($sformatf("rd_wait1_a%0d", addr), 32'(avs_waitrequest), 32'h1);
        @(posedge clk);
        #1;
        checkOutput($sformatf("rd_wait0_a%0d", addr), 32'(avs_waitrequest), 32'h0);
        data           = avs_readdata;
        avs_chipselect = 1'b0;
        avs_read       = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic readCheck(input logic [3:0] addr, input logic [31:0] expected, input string tag);
        logic [31:0] d;
        readReg(addr, d);
        checkOutput(tag, d, expected);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst_n          = 1'b0;
        avs_chipselect = 1'b0;
        avs_address    = 4'd0;
        avs_read       = 1'b0;
        avs_write      = 1'b0;
        avs_writedata  = 32'h0;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_irq", 32'(irq), 32'h0);
        checkOutput("rst_wait", 32'(avs_waitrequest), 32'h0);
        checkOutput("rst_rdata", avs_readdata, 32'h0);
        rst_n = 1'b1;
        idle(1);

        // Reset in the middle of a read abandons it immediately.
        avs_chipselect = 1'b1;
        avs_read       = 1'b1;
        avs_address    = ADDR_MASK;
        #1;
        checkOutput("midrd_wait1", 32'(avs_waitrequest), 32'h1);
        rst_n = 1'b0;
        #1;
        checkOutput("midrd_wait_rst", 32'(avs_waitrequest), 32'h0);
        @(posedge clk);
        #1;
        checkOutput("midrd_wait_hold", 32'(avs_waitrequest), 32'h0);
        avs_chipselect = 1'b0;
        avs_read       = 1'b0;
        rst_n          = 1'b1;
        idle(1);

        for (int a = 0; a < 16; a++) begin
            readCheck(4'(a), 32'h0, $sformatf("rst_read_a%0d", a));
        end
        checkOutput("rst_irq_after_reads", 32'(irq), 32'h0);

        // Edge mode: pending latches, survives the falling write and masking.
        applyStimulus(ADDR_MASK, 32'h1);
        applyStimulus(ADDR_CTRL, 32'h0);
        applyStimulus(ADDR_REQ, IRQ_SET);
        checkOutput("edge_irq_latency", 32'(irq), 32'h0);
        idle(1);
        checkOutput("edge_irq_set", 32'(irq), 32'h1);
        readCheck(ADDR_STATUS, 32'h1, "edge_status");
        readCheck(ADDR_COUNT, 32'h1, "edge_count");
        applyStimulus(ADDR_REQ, IRQ_CLR);
        idle(1);
        checkOutput("edge_irq_after_clr", 32'(irq), 32'h1);
        readCheck(ADDR_REQ, 32'h0, "edge_level_clr");
        applyStimulus(ADDR_MASK, 32'h0);
        idle(1);
        checkOutput("mask_irq_off", 32'(irq), 32'h0);
        readCheck(ADDR_STATUS, 32'h1, "mask_keeps_pending");
        applyStimulus(ADDR_MASK, 32'h1);
        idle(1);
        checkOutput("mask_irq_on", 32'(irq), 32'h1);
        applyStimulus(ADDR_STATUS, 32'h1);
        checkOutput("w1c_irq_latency", 32'(irq), 32'h1);
        idle(1);
        checkOutput("w1c_irq_off", 32'(irq), 32'h0);
        readCheck(ADDR_STATUS, 32'h0, "w1c_status");

        // W1C while the level is still high: only a fresh rising edge re-arms.
        applyStimulus(ADDR_REQ, IRQ_SET);
        applyStimulus(ADDR_STATUS, 32'h1);
        readCheck(ADDR_STATUS, 32'h0, "w1c_level_high");
        applyStimulus(ADDR_REQ, IRQ_SET);
        readCheck(ADDR_STATUS, 32'h0, "repeat_set_no_pend");
        readCheck(ADDR_COUNT, 32'h2, "repeat_set_no_count");
        checkOutput("repeat_set_irq", 32'(irq), 32'h0);
        applyStimulus(ADDR_REQ, IRQ_CLR);

        // Level mode: irq follows level with one cycle of latency.
        applyStimulus(ADDR_COUNT, 32'h0);
        applyStimulus(ADDR_CTRL, 32'h1);
        applyStimulus(ADDR_REQ, IRQ_SET);
        idle(1);
        checkOutput("lvl_irq_high", 32'(irq), 32'h1);
        applyStimulus(ADDR_REQ, IRQ_CLR);
        checkOutput("lvl_irq_latency", 32'(irq), 32'h1);
        idle(1);
        checkOutput("lvl_irq_low", 32'(irq), 32'h0);
        readCheck(ADDR_COUNT, 32'h1, "lvl_count");
        readCheck(ADDR_CTRL, 32'h1, "lvl_ctrl_rb");
        applyStimulus(ADDR_STATUS, 32'h1);
        applyStimulus(ADDR_CTRL, 32'h0);

        // Holdoff of 5: W1C at edge E, re-armed at E+2, counter hits 0 at E+5, irq at E+6.
        applyStimulus(ADDR_HOLDOFF, 32'h5);
        readCheck(ADDR_HOLDOFF, 32'h5, "hold_rb");
        applyStimulus(ADDR_REQ, IRQ_SET);
        idle(1);
        checkOutput("hold_pre_irq", 32'(irq), 32'h1);
        applyStimulus(ADDR_STATUS, 32'h1);
        applyStimulus(ADDR_REQ, IRQ_CLR);
        applyStimulus(ADDR_REQ, IRQ_SET);
        checkOutput("hold_e2", 32'(irq), 32'h0);
        idle(1);
        checkOutput("hold_e3", 32'(irq), 32'h0);
        idle(1);
        checkOutput("hold_e4", 32'(irq), 32'h0);
        idle(1);
        checkOutput("hold_e5", 32'(irq), 32'h0);
        idle(1);
        checkOutput("hold_e6", 32'(irq), 32'h1);
        readCheck(ADDR_STATUS, 32'h1, "hold_status");
        applyStimulus(ADDR_HOLDOFF, 32'h0);
        applyStimulus(ADDR_STATUS, 32'h1);
        applyStimulus(ADDR_REQ, IRQ_CLR);
        idle(1);
        checkOutput("hold_cleanup_irq", 32'(irq), 32'h0);

        // 2^4+3 rising edges wrap the 4-bit counter to 3; any write clears it.
        applyStimulus(ADDR_COUNT, 32'h0);
        for (int i = 0; i < 19; i++) begin
            applyStimulus(ADDR_REQ, IRQ_SET);
            applyStimulus(ADDR_REQ, IRQ_CLR);
        end
        readCheck(ADDR_COUNT, 32'h3, "count_wrap");
        applyStimulus(ADDR_COUNT, 32'hDEAD_BEEF);
        readCheck(ADDR_COUNT, 32'h0, "count_clear");

        // Unmapped addresses, and read+write together acting as a write.
        applyStimulus(4'd9, 32'hFFFF_FFFF);
        readCheck(4'd9, 32'h0, "unmapped_read");
        avs_chipselect = 1'b1;
        avs_read       = 1'b1;
        avs_write      = 1'b1;
        avs_address    = ADDR_MASK;
        avs_writedata  = 32'h0;
        #1;
        checkOutput("rdwr_wait", 32'(avs_waitrequest), 32'h0);
        @(posedge clk);
        #1;
        avs_chipselect = 1'b0;
        avs_read       = 1'b0;
        avs_write      = 1'b0;
        readCheck(ADDR_MASK, 32'h0, "rdwr_as_write");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
